// File: rtl/vscale_ihex_pkg.sv
// Shared types and constants for the Intel-HEX program loader.
package vscale_ihex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ADDR,
    ST_TYPE,
    ST_DATA,
    ST_CKSUM,
    ST_DONE,
    ST_ERROR
  } ihex_state_t;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_BAD_CHAR    = 3'd1;
  localparam logic [2:0] ERR_CKSUM       = 3'd2;
  localparam logic [2:0] ERR_UNSUPPORTED = 3'd3;
  localparam logic [2:0] ERR_RANGE       = 3'd4;

  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;
  localparam logic [7:0] REC_ESA  = 8'h04;
  localparam logic [7:0] REC_SLA  = 8'h05;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/vscale_hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f -> nibble value.
module vscale_hex_ascii_decode (
  input  logic [7:0] in,
  output logic [3:0] nib,
  output logic       is_hex
);

  // Letters A-F / a-f have low nibble 1..6, so value = low nibble + 9.
  always_comb begin
    nib    = 4'h0;
    is_hex = 1'b0;
    if (in >= 8'h30 && in <= 8'h39) begin
      nib    = in[3:0];
      is_hex = 1'b1;
    end else if ((in >= 8'h41 && in <= 8'h46) || (in >= 8'h61 && in <= 8'h66)) begin
      nib    = in[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/vscale_ihex_loader.sv
// Intel-HEX record parser that writes little-endian 32-bit words into program
// memory and holds the core in reset until a valid EOF record is accepted.
module vscale_ihex_loader
  import vscale_ihex_pkg::*;
#(
  parameter int MEM_WORDS       = 8192,
  parameter int WORD_ADDR_WIDTH = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       mem_we,
  output logic [WORD_ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]                mem_wdata,
  output logic                       core_reset,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 err_code
);

  ihex_state_t                state_reg, state_next;
  logic                       lo_phase_reg, lo_phase_next;   // next digit completes a byte
  logic [3:0]                 hi_nib_reg, hi_nib_next;
  logic [7:0]                 byte_cnt_reg, byte_cnt_next;   // bytes done in current field
  logic [7:0]                 bytec_reg, bytec_next;
  logic [15:0]                addr_reg, addr_next;
  logic [7:0]                 rtype_reg, rtype_next;
  logic [7:0]                 sum_reg, sum_next;
  logic [23:0]                word_reg, word_next;           // lower three bytes of current word
  logic [WORD_ADDR_WIDTH-1:0] widx_reg, widx_next;
  logic                       mem_we_reg, mem_we_next;
  logic [WORD_ADDR_WIDTH-1:0] mem_waddr_reg, mem_waddr_next;
  logic [31:0]                mem_wdata_reg, mem_wdata_next;
  logic [2:0]                 err_code_reg, err_code_next;
  logic                       rx_ready_reg, rx_ready_next;

  logic       xfer;
  logic [3:0] nib;
  logic       is_hex;
  logic [7:0] byte_val;
  logic [7:0] sum_add;
  logic       bytec_ok;
  logic [16:0] range_end;

  vscale_hex_ascii_decode u_decode (
    .in    (rx_data),
    .nib   (nib),
    .is_hex(is_hex)
  );

  assign xfer      = rx_valid & rx_ready_reg;
  assign byte_val  = {hi_nib_reg, nib};
  assign sum_add   = sum_reg + byte_val;
  assign bytec_ok  = (bytec_reg[1:0] == 2'b00) && (bytec_reg != 8'd0) && (bytec_reg <= 8'd16);
  assign range_end = {3'b000, addr_reg[15:2]} + {11'b0, bytec_reg[7:2]};

  // State and datapath registers; reset aborts any record in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      lo_phase_reg  <= 1'b0;
      hi_nib_reg    <= 4'h0;
      byte_cnt_reg  <= 8'd0;
      bytec_reg     <= 8'd0;
      addr_reg      <= 16'd0;
      rtype_reg     <= 8'd0;
      sum_reg       <= 8'd0;
      word_reg      <= 24'd0;
      widx_reg      <= '0;
      mem_we_reg    <= 1'b0;
      mem_waddr_reg <= '0;
      mem_wdata_reg <= 32'd0;
      err_code_reg  <= ERR_NONE;
      rx_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lo_phase_reg  <= lo_phase_next;
      hi_nib_reg    <= hi_nib_next;
      byte_cnt_reg  <= byte_cnt_next;
      bytec_reg     <= bytec_next;
      addr_reg      <= addr_next;
      rtype_reg     <= rtype_next;
      sum_reg       <= sum_next;
      word_reg      <= word_next;
      widx_reg      <= widx_next;
      mem_we_reg    <= mem_we_next;
      mem_waddr_reg <= mem_waddr_next;
      mem_wdata_reg <= mem_wdata_next;
      err_code_reg  <= err_code_next;
      rx_ready_reg  <= rx_ready_next;
    end
  end

  // Record parser: advances one character per accepted transfer.
  always_comb begin
    state_next     = state_reg;
    lo_phase_next  = lo_phase_reg;
    hi_nib_next    = hi_nib_reg;
    byte_cnt_next  = byte_cnt_reg;
    bytec_next     = bytec_reg;
    addr_next      = addr_reg;
    rtype_next     = rtype_reg;
    sum_next       = sum_reg;
    word_next      = word_reg;
    widx_next      = widx_reg;
    mem_we_next    = 1'b0;
    mem_waddr_next = mem_waddr_reg;
    mem_wdata_next = mem_wdata_reg;
    err_code_next  = err_code_reg;

    if (xfer) begin
      case (state_reg)
        ST_IDLE: begin
          if (rx_data == CH_COLON) begin
            state_next    = ST_COUNT;
            lo_phase_next = 1'b0;
            byte_cnt_next = 8'd0;
            sum_next      = 8'd0;
          end else if (rx_data != CH_CR && rx_data != CH_LF && rx_data != CH_SPACE) begin
            state_next    = ST_ERROR;
            err_code_next = ERR_BAD_CHAR;
          end
        end
        ST_DONE, ST_ERROR: begin
          // characters are swallowed; outcome is already latched
        end
        default: begin
          if (!is_hex) begin
            state_next    = ST_ERROR;
            err_code_next = ERR_BAD_CHAR;
          end else if (!lo_phase_reg) begin
            hi_nib_next   = nib;
            lo_phase_next = 1'b1;
          end else begin
            lo_phase_next = 1'b0;
            sum_next      = sum_add;
            case (state_reg)
              ST_COUNT: begin
                bytec_next    = byte_val;
                byte_cnt_next = 8'd0;
                state_next    = ST_ADDR;
              end
              ST_ADDR: begin
                addr_next     = {addr_reg[7:0], byte_val};
                byte_cnt_next = byte_cnt_reg + 8'd1;
                if (byte_cnt_reg == 8'd1) state_next = ST_TYPE;
              end
              ST_TYPE: begin
                rtype_next    = byte_val;
                byte_cnt_next = 8'd0;
                word_next     = 24'd0;
                widx_next     = WORD_ADDR_WIDTH'(addr_reg[15:2]);
                state_next    = (bytec_reg == 8'd0) ? ST_CKSUM : ST_DATA;
                // Type legality is decided here, before any data byte arrives.
                case (byte_val)
                  REC_DATA: begin
                    if (!bytec_ok || addr_reg[1:0] != 2'b00) begin
                      state_next    = ST_ERROR;
                      err_code_next = ERR_UNSUPPORTED;
                    end else if (range_end > 17'(MEM_WORDS)) begin
                      state_next    = ST_ERROR;
                      err_code_next = ERR_RANGE;
                    end
                  end
                  REC_EOF: begin
                    if (bytec_reg != 8'd0) begin
                      state_next    = ST_ERROR;
                      err_code_next = ERR_UNSUPPORTED;
                    end
                  end
                  REC_ESA, REC_SLA: begin
                  end
                  default: begin
                    state_next    = ST_ERROR;
                    err_code_next = ERR_UNSUPPORTED;
                  end
                endcase
              end
              ST_DATA: begin
                byte_cnt_next = byte_cnt_reg + 8'd1;
                case (byte_cnt_reg[1:0])
                  2'd0: word_next[7:0]   = byte_val;
                  2'd1: word_next[15:8]  = byte_val;
                  2'd2: word_next[23:16] = byte_val;
                  default: begin
                    // Word complete: written now, before the checksum is known.
                    if (rtype_reg == REC_DATA) begin
                      mem_we_next    = 1'b1;
                      mem_waddr_next = widx_reg;
                      mem_wdata_next = {byte_val, word_reg};
                      widx_next      = widx_reg + WORD_ADDR_WIDTH'(1);
                    end
                  end
                endcase
                if (byte_cnt_reg == bytec_reg - 8'd1) state_next = ST_CKSUM;
              end
              ST_CKSUM: begin
                if (sum_add != 8'd0) begin
                  state_next    = ST_ERROR;
                  err_code_next = ERR_CKSUM;
                end else if (rtype_reg == REC_EOF) begin
                  state_next = ST_DONE;
                end else begin
                  state_next = ST_IDLE;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end

    rx_ready_next = (state_next != ST_DONE);
  end

  assign rx_ready   = rx_ready_reg;
  assign mem_we     = mem_we_reg;
  assign mem_waddr  = mem_waddr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign done       = (state_reg == ST_DONE);
  assign err        = (state_reg == ST_ERROR);
  assign core_reset = (state_reg != ST_DONE);
  assign err_code   = err_code_reg;

endmodule

// File: tb/tb_vscale_ihex_loader.sv
// Self-checking bench for vscale_ihex_loader: a string-level ihex model
// predicts writes and final status; a monitor checks every write strobe.
module tb_vscale_ihex_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        err;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  vscale_ihex_loader #(.MEM_WORDS(8192), .WORD_ADDR_WIDTH(13)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .core_reset(core_reset),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  int          n_checks = 0;
  int          n_errs = 0;
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          m_done, m_err;
  int          m_code;
  int          wr_count = 0;
  int          last_waddr = 0;
  logic [31:0] last_wdata = 0;

  string T1  = ":0400000013000000E8";
  string T2  = ":10001000000102030405060708090A0B0C0D0E0F68";
  string EOF = ":00000001FF";
  string CRLF = "\015\012";

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int hexv(byte c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  // One byte from two hex chars: -2 stream ends, -1 bad character.
  task automatic model_byte(input string s, inout int p, output int v);
    int h, l;
    if (p >= s.len()) begin v = -2; return; end
    h = hexv(s[p]); p++;
    if (h < 0) begin v = -1; return; end
    if (p >= s.len()) begin v = -2; return; end
    l = hexv(s[p]); p++;
    v = (l < 0) ? -1 : h * 16 + l;
  endtask

  task automatic model_fail(input int code);
    m_err = 1;
    m_code = code;
  endtask

  task automatic model_run(input string s);
    int p, cnt, addr, ty, b, sum, word;
    int f[4];
    p = 0;
    while (p < s.len() && !m_done && !m_err) begin
      if (s[p] == 8'h20 || s[p] == 8'h0d || s[p] == 8'h0a) begin p++; continue; end
      if (s[p] != 8'h3a) begin model_fail(1); return; end
      p++;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        model_byte(s, p, f[i]);
        if (f[i] == -1) model_fail(1);
        if (f[i] < 0) return;
        sum += f[i];
      end
      cnt = f[0]; addr = f[1] * 256 + f[2]; ty = f[3];
      if (ty == 0) begin
        if (!(cnt == 4 || cnt == 8 || cnt == 12 || cnt == 16) || addr % 4 != 0) begin model_fail(3); return; end
        if (addr / 4 + cnt / 4 > 8192) begin model_fail(4); return; end
      end else if (ty == 1) begin
        if (cnt != 0) begin model_fail(3); return; end
      end else if (ty != 4 && ty != 5) begin
        model_fail(3); return;
      end
      word = 0;
      for (int k = 0; k < cnt; k++) begin
        model_byte(s, p, b);
        if (b == -1) model_fail(1);
        if (b < 0) return;
        sum += b;
        word = word | (b << (8 * (k % 4)));
        if (k % 4 == 3) begin
          if (ty == 0) begin
            exp_addr_q.push_back(addr / 4 + k / 4);
            exp_data_q.push_back(word);
          end
          word = 0;
        end
      end
      model_byte(s, p, b);
      if (b == -1) model_fail(1);
      if (b < 0) return;
      sum += b;
      if (sum % 256 != 0) begin model_fail(2); return; end
      if (ty == 1) m_done = 1;
    end
  endtask

  // ---------------- write monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset) chk("core_reset_vs_done", {31'b0, core_reset}, {31'b0, !done});
      if (mem_we) begin
        wr_count++;
        last_waddr = int'(mem_waddr);
        last_wdata = mem_wdata;
        $display("write waddr=%0d wdata=%08h", mem_waddr, mem_wdata);
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_write got waddr=%0d wdata=%08h exp none", mem_waddr, mem_wdata);
        end else begin
          chk("write_addr", {19'b0, mem_waddr}, exp_addr_q.pop_front());
          chk("write_data", mem_wdata, exp_data_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_char(input byte c, input int gap);
    int t;
    t = 0;
    for (int g = 0; g < gap; g++) begin @(negedge clk); rx_valid = 1'b0; end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = c;
    while (!rx_ready && t < 50) begin @(negedge clk); t++; end
    if (!rx_ready) begin
      n_checks++;
      n_errs++;
      $display("FAIL rx_ready_timeout got=0 exp=1");
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic send_str(input string s, input int max_gap);
    $display("send chars=%0d max_gap=%0d", s.len(), max_gap);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run(input string s, input int max_gap);
    model_run(s);
    send_str(s, max_gap);
  endtask

  task automatic check_status(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done"}, {31'b0, done}, {31'b0, m_done});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, m_err});
    chk({tag, "_err_code"}, {29'b0, err_code}, m_code);
    chk({tag, "_core_reset"}, {31'b0, core_reset}, {31'b0, !m_done});
    chk({tag, "_pending_writes"}, exp_addr_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", {31'b0, rx_ready}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_waddr", {19'b0, mem_waddr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_core_reset", {31'b0, core_reset}, 1);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_err_code", {29'b0, err_code}, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    m_done = 0; m_err = 0; m_code = 0;
    wr_count = 0;
    reset = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    string t1, s3, pre, mix;
    t1 = ":0400000013000000E9";

    // Test 1: single word
    do_reset();
    model_run(t1);
    chk("model_t1_count", exp_addr_q.size(), 1);
    chk("model_t1_addr", exp_addr_q[0], 0);
    chk("model_t1_data", exp_data_q[0], 32'h00000013);
    send_str(t1, 0);
    check_status("t1");
    chk("t1_wr_count", wr_count, 1);
    chk("t1_last_waddr", last_waddr, 0);
    chk("t1_last_wdata", last_wdata, 32'h00000013);

    // Test 2: 16-byte record at 0x0010
    do_reset();
    model_run(T2);
    chk("model_t2_count", exp_addr_q.size(), 4);
    chk("model_t2_addr0", exp_addr_q[0], 4);
    chk("model_t2_data0", exp_data_q[0], 32'h03020100);
    chk("model_t2_addr3", exp_addr_q[3], 7);
    chk("model_t2_data3", exp_data_q[3], 32'h0F0E0D0C);
    send_str(T2, 0);
    check_status("t2");
    chk("t2_wr_count", wr_count, 4);
    chk("t2_last_wdata", last_wdata, 32'h0F0E0D0C);

    // Test 3: data record, CRLF, EOF; done exactly one cycle after final 'F'
    do_reset();
    s3 = {t1, CRLF, EOF};
    model_run(s3);
    chk("model_t3_done", {31'b0, m_done}, 1);
    pre = s3.substr(0, s3.len() - 2);
    send_str(pre, 0);
    chk("t3_done_before_last", {31'b0, done}, 0);
    chk("t3_core_reset_before_last", {31'b0, core_reset}, 1);
    send_char(8'h46, 0);
    #1;
    chk("t3_done_after_last", {31'b0, done}, 1);
    chk("t3_core_reset_after_last", {31'b0, core_reset}, 0);
    chk("t3_rx_ready_after_last", {31'b0, rx_ready}, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check_status("t3");

    // Test 4a: bad checksum after the word was written
    do_reset();
    model_run(T1);
    chk("model_t4a_code", m_code, 2);
    send_str(T1, 0);
    check_status("t4a");
    chk("t4a_wr_count", wr_count, 1);

    // Test 4b: unsupported record type 2
    do_reset();
    run(":020000021000EC", 0);
    chk("model_t4b_code", m_code, 3);
    check_status("t4b");
    chk("t4b_wr_count", wr_count, 0);

    // Test 4c: 'G' inside data
    do_reset();
    run(":04000000130G0000E9", 0);
    chk("model_t4c_code", m_code, 1);
    check_status("t4c");

    // Test 4d: ':' inside a record
    do_reset();
    run(":0400:", 0);
    check_status("t4d");

    // Test 5: address out of range
    do_reset();
    run(":048000001300000069", 0);
    chk("model_t5_code", m_code, 4);
    check_status("t5");
    chk("t5_wr_count", wr_count, 0);

    // Test 6: reset after 5 data nibbles, then resend test 1
    do_reset();
    run(":0400000013000", 0);
    do_reset();
    run(t1, 0);
    check_status("t6");
    chk("t6_wr_count", wr_count, 1);
    chk("t6_last_wdata", last_wdata, 32'h00000013);

    // Mixed stream, back-to-back then with random gaps
    mix = {":020000040000FA", CRLF, ":0400000013000000e9", CRLF, " ", T2, CRLF, EOF};
    do_reset();
    run(mix, 0);
    check_status("mix_b2b");
    chk("mix_b2b_wr_count", wr_count, 5);
    do_reset();
    run(mix, 3);
    check_status("mix_gaps");
    chk("mix_gaps_wr_count", wr_count, 5);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
